// File: rtl/seq_multiplier_n_if.sv
// Start/busy/done handshake bundle for seq_multiplier_n.
// master drives the operands; slave is the multiplier.
interface seq_multiplier_n_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start,
    output signed_mode,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  signed_mode,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/seq_multiplier_n.sv
// Shift-add multiplier, one multiplier bit per cycle, signed or unsigned.
// SEQ_MULT_EARLY_TERM_EN: skip trailing zero multiplier bits in one shift.
module seq_multiplier_n #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  seq_multiplier_n_if.slave mul
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               x_q, x_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     ext_m;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic               last;
  logic               fill;
  logic [CW-1:0]      cnt_nx;
  logic [PW-1:0]      shifted;

  // Final signed iteration weights the sign bit negatively.
  assign ext_m   = {sgn_q & m_q[WIDTH-1], m_q};
  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign addend  = !b_q[0] ? '0 :
                   (sgn_q && last) ? (~ext_m + 1'b1) : ext_m;
  assign sum     = {x_q, a_q} + addend;
  assign fill    = sgn_q & sum[WIDTH];
  assign cnt_nx  = cnt_q + 1'b1;
  assign shifted = {fill, sum, b_q[WIDTH-1:1]};

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [WIDTH-1:0]   low_mask;
  logic [CW-1:0]      rem;
  logic               early;
  logic [PW-1:0]      jumped;

  assign low_mask = {WIDTH{1'b1}} >> cnt_nx;
  assign rem      = CW'(WIDTH) - cnt_nx;
  assign early    = (cnt_nx < CW'(WIDTH)) &&
                    ((shifted[WIDTH-1:0] & low_mask) == '0);
  assign jumped   = PW'($signed(shifted) >>> rem);
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (mul.start) begin
          m_d     = mul.multiplicand;
          b_d     = mul.multiplier;
          sgn_d   = mul.signed_mode;
          x_d     = 1'b0;
          a_d     = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      (state_q == S_CALC): begin
        {x_d, a_d, b_d} = shifted;
        cnt_d = cnt_nx;
        if (cnt_nx == CW'(WIDTH)) begin
          state_d = S_DONE;
        end
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (early) begin
          {x_d, a_d, b_d} = jumped;
          cnt_d   = CW'(WIDTH);
          state_d = S_DONE;
        end
`endif
      end
      (state_q == S_DONE): begin
        prod_d  = {a_q, b_q};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign mul.busy    = (state_q != S_IDLE);
  assign mul.done    = done_q;
  assign mul.product = prod_q;
endmodule

// File: tb/tb_seq_multiplier_n.sv
// Directed-vector bench for seq_multiplier_n at WIDTH 8 and 16.
// Latency expectations follow SEQ_MULT_EARLY_TERM_EN when defined.
module tb_seq_multiplier_n;
  logic clk = 1'b0;
  logic rst8;
  logic rst16;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_multiplier_n_if #(.WIDTH(8))  i8 ();
  seq_multiplier_n_if #(.WIDTH(16)) i16 ();

  seq_multiplier_n #(.WIDTH(8)) u8 (
    .clk   (clk),
    .reset (rst8),
    .mul   (i8)
  );

  seq_multiplier_n #(.WIDTH(16)) u16 (
    .clk   (clk),
    .reset (rst16),
    .mul   (i16)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int w, input logic [15:0] q);
    int l;
    l = w + 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    l = 2;
    for (int i = 0; i < w; i++)
      if (q[i]) l = i + 2;
`endif
    return l;
  endfunction

  task automatic wait_done(input bit w16, output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (w16 ? i16.done : i8.done) begin
        k = i;
        return;
      end
    end
  endtask

  task automatic run_op(input string tag, input bit w16, input bit sm,
                        input logic [15:0] m, input logic [15:0] q,
                        input logic [31:0] exp);
    int k;
    @(negedge clk);
    if (w16) begin
      i16.signed_mode = sm; i16.multiplicand = m;
      i16.multiplier = q; i16.start = 1'b1;
    end else begin
      i8.signed_mode = sm; i8.multiplicand = m[7:0];
      i8.multiplier = q[7:0]; i8.start = 1'b1;
    end
    @(posedge clk); #1;
    i8.start = 1'b0;
    i16.start = 1'b0;
    check({tag, "_busy"}, 32'(w16 ? i16.busy : i8.busy), 32'd1);
    wait_done(w16, k);
    check({tag, "_lat"}, 32'(k), 32'(exp_lat(w16 ? 16 : 8, q)));
    check({tag, "_prod"},
          w16 ? i16.product : {16'h0, i8.product}, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(w16 ? i16.done : i8.done), 32'd0);
  endtask

  initial begin
    int nd;
    int de;
    int k;
    logic [15:0] pr;
    i8.start = 0; i8.signed_mode = 0;
    i8.multiplicand = 0; i8.multiplier = 0;
    i16.start = 0; i16.signed_mode = 0;
    i16.multiplicand = 0; i16.multiplier = 0;
    rst8 = 1'b1;
    rst16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0;
    rst16 = 1'b0;
    check("rst_busy", 32'(i8.busy), 32'd0);
    check("rst_done", 32'(i8.done), 32'd0);
    check("rst_prod", {16'h0, i8.product}, 32'h0);
    check("rst_prod16", i16.product, 32'h0);

    run_op("s_7xfd",   0, 1, 16'h07, 16'hFD, 32'hFFEB);
    run_op("u_ffxff",  0, 0, 16'hFF, 16'hFF, 32'hFE01);
    run_op("s_ffxff",  0, 1, 16'hFF, 16'hFF, 32'h0001);
    run_op("s_80x80",  0, 1, 16'h80, 16'h80, 32'h4000);
    run_op("u_80x80",  0, 0, 16'h80, 16'h80, 32'h4000);
    run_op("s_80x01",  0, 1, 16'h80, 16'h01, 32'hFF80);
    run_op("u_00x5a",  0, 0, 16'h00, 16'h5A, 32'h0000);
    run_op("u_5ax00",  0, 0, 16'h5A, 16'h00, 32'h0000);
    run_op("s_7fx7f",  0, 1, 16'h7F, 16'h7F, 32'h3F01);
    run_op("s_7fx80",  0, 1, 16'h7F, 16'h80, 32'hC080);

    // Handshake: extra starts while busy, operands changed after capture
    @(negedge clk);
    i8.signed_mode = 0; i8.multiplicand = 8'h03;
    i8.multiplier = 8'h05; i8.start = 1;
    @(posedge clk); #1;
    i8.start = 0;
    i8.multiplicand = 8'h0A;
    i8.multiplier = 8'h0B;
    nd = 0;
    de = -1;
    pr = 16'h0;
    for (int e = 1; e <= 9; e++) begin
      if (e == 3) i8.start = 1;
`ifndef SEQ_MULT_EARLY_TERM_EN
      if (e == 9) i8.start = 1;
`endif
      @(posedge clk); #1;
      i8.start = 0;
      if (i8.done) begin
        nd++;
        de = e;
        pr = i8.product;
      end
    end
    check("hs_ndone", 32'(nd), 32'd1);
    check("hs_lat", 32'(de), 32'(exp_lat(8, 16'h05)));
    check("hs_prod", {16'h0, pr}, 32'h000F);
    check("hs_idle9", 32'(i8.busy), 32'd0);
    i8.start = 1;
    @(posedge clk); #1;
    i8.start = 0;
    check("hs_acc10", 32'(i8.busy), 32'd1);
    wait_done(0, k);
    check("hs_lat10", 32'(k), 32'(exp_lat(8, 16'h0B)));
    check("hs_prod10", {16'h0, i8.product}, 32'h006E);

    // Reset in the middle of an operation
    @(negedge clk);
    i8.signed_mode = 0; i8.multiplicand = 8'h55;
    i8.multiplier = 8'h66; i8.start = 1;
    @(posedge clk); #1;
    i8.start = 0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 32'(i8.busy), 32'd1);
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    check("mid_rst_busy", 32'(i8.busy), 32'd0);
    check("mid_rst_prod", {16'h0, i8.product}, 32'h0);
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (i8.done) nd++;
    end
    check("mid_rst_nodone", 32'(nd), 32'd0);

    // Reset and start in the same cycle: reset wins
    @(negedge clk);
    rst8 = 1'b1;
    i8.multiplicand = 8'h21; i8.multiplier = 8'h43; i8.start = 1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    i8.start = 0;
    check("rst_start_busy", 32'(i8.busy), 32'd0);
    run_op("u_12x34",  0, 0, 16'h12, 16'h34, 32'h03A8);

    run_op("s16_8000x7fff", 1, 1, 16'h8000, 16'h7FFF, 32'hC0008000);
    run_op("u16_ffffxffff", 1, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op("s16_ffffx0001", 1, 1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
